// File: rtl/rr_sched_pkg.sv
// rr_sched_pkg: shared types, default sizes and helpers for the round-robin burst scheduler.
package rr_sched_pkg;
  typedef enum logic {IDLE, BUSY} rr_state_t;
  localparam int DEF_N_CH = 4;
  localparam int DEF_MAX_BURST = 16;
  function automatic logic [31:0] onehot(input int idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating priority encoder, first requester at or after rr_ptr wins.
module rr_pick #(
  parameter int N_CH = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  always_comb begin
    any = 1'b0;
    idx = rr_ptr;
    // Scan farthest-first so the closest requester to rr_ptr overwrites last.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N_CH]) begin
        any = 1'b1;
        idx = SEL_W'((int'(rr_ptr) + k) % N_CH);
      end
    end
  end
endmodule

// File: rtl/rr_sel_sched.sv
// rr_sel_sched: round-robin burst scheduler driving a registered, never-X mux select
// with a valid/ready beat handshake and back-to-back grants.
module rr_sel_sched
  import rr_sched_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int SEL_W = $clog2(N_CH),
  localparam int BURST_W = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               ready,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic [N_CH-1:0]    grant,
  output logic               last
);
  rr_state_t state;
  logic [SEL_W-1:0] rr_ptr, ptr_nxt, sel_inc, pick_idx;
  logic [BURST_W-1:0] len_q, beat_cnt, len_in;
  logic beat, burst_end, pick_any;

  always_comb begin
    beat = sel_valid && ready;
    // A beat ends the burst only on last; with no beat a dropped request ends it.
    burst_end = (state == BUSY) && (beat ? last : !req[sel]);
    sel_inc = (sel == SEL_W'(N_CH - 1)) ? '0 : sel + SEL_W'(1);
    ptr_nxt = burst_end ? sel_inc : rr_ptr;
    len_in = (burst_len == '0) ? BURST_W'(1) :
             (burst_len > BURST_W'(MAX_BURST)) ? BURST_W'(MAX_BURST) : burst_len;
  end

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req(req),
    .rr_ptr(ptr_nxt),
    .any(pick_any),
    .idx(pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      sel_valid <= 1'b0;
      grant <= '0;
      last <= 1'b0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      len_q <= '0;
    end else begin
      if (burst_end) rr_ptr <= ptr_nxt;
      if (state == IDLE || burst_end) begin
        if (pick_any) begin
          state <= BUSY;
          sel <= pick_idx;
          sel_valid <= 1'b1;
          grant <= N_CH'(onehot(int'(pick_idx)));
          len_q <= len_in;
          beat_cnt <= '0;
          last <= (len_in == BURST_W'(1));
        end else begin
          state <= IDLE;
          sel_valid <= 1'b0;
          grant <= '0;
          last <= 1'b0;
          beat_cnt <= '0;
        end
      end else if (beat) begin
        beat_cnt <= beat_cnt + BURST_W'(1);
        last <= (beat_cnt + BURST_W'(2)) == len_q;
      end
    end
  end
endmodule

// File: tb/tb_rr_sel_sched.sv
// tb_rr_sel_sched: directed table, corner sequences and randomized run against a
// transaction-level model that tracks remaining beats per burst.
module tb_rr_sel_sched;
  localparam int N = 4;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [4:0] burst_len = '0;
  logic ready = 1'b0;
  logic [1:0] sel;
  logic sel_valid;
  logic [3:0] grant;
  logic last;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int m_valid, m_sel, m_ptr, m_left;

  typedef struct {
    logic [3:0] req;
    logic [4:0] len;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  rr_sel_sched dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .burst_len(burst_len),
    .ready(ready),
    .sel(sel),
    .sel_valid(sel_valid),
    .grant(grant),
    .last(last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_sel = 0;
    m_ptr = 0;
    m_left = 0;
  endtask

  function automatic int sat(input int l);
    return (l == 0) ? 1 : (l > MB) ? MB : l;
  endfunction

  task automatic model_step();
    int b, e;
    b = (m_valid != 0) && ready;
    e = (m_valid != 0) && ((b != 0 && m_left == 1) || (!req[m_sel] && b == 0));
    if (e != 0) m_ptr = (m_sel + 1) % N;
    if (m_valid == 0 || e != 0) begin
      m_valid = 0;
      for (int k = 0; k < N; k++) begin
        if (m_valid == 0 && req[(m_ptr + k) % N]) begin
          m_valid = 1;
          m_sel = (m_ptr + k) % N;
          m_left = sat(int'(burst_len));
        end
      end
    end else if (b != 0) begin
      m_left--;
    end
  endtask

  function automatic logic [7:0] exp_out();
    logic [3:0] g;
    g = (m_valid != 0) ? 4'(1 << m_sel) : 4'b0;
    return {2'(m_sel), m_valid != 0, g, (m_valid != 0) && (m_left == 1)};
  endfunction

  function automatic logic [7:0] dut_out();
    return {sel, sel_valid, grant, last};
  endfunction

  task automatic drive(input logic [3:0] r, input logic [4:0] l, input logic rd);
    req = r;
    burst_len = l;
    ready = rd;
  endtask

  task automatic step(input string name);
    if (sel_valid && ready) beats++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check(name, 32'(dut_out()), 32'(exp_out()));
  endtask

  initial begin
    // round robin 0,1,2,3,0 then idle; then single channel 2, three beats
    tbl[0] = '{4'b1111, 5'd1, 1'b1, 8'b00_1_0001_1};
    tbl[1] = '{4'b1111, 5'd1, 1'b1, 8'b01_1_0010_1};
    tbl[2] = '{4'b1111, 5'd1, 1'b1, 8'b10_1_0100_1};
    tbl[3] = '{4'b1111, 5'd1, 1'b1, 8'b11_1_1000_1};
    tbl[4] = '{4'b1111, 5'd1, 1'b1, 8'b00_1_0001_1};
    tbl[5] = '{4'b0000, 5'd1, 1'b1, 8'b00_0_0000_0};
    tbl[6] = '{4'b0100, 5'd3, 1'b1, 8'b10_1_0100_0};
    tbl[7] = '{4'b0100, 5'd3, 1'b1, 8'b10_1_0100_0};
    tbl[8] = '{4'b0100, 5'd3, 1'b1, 8'b10_1_0100_1};
    tbl[9] = '{4'b0000, 5'd3, 1'b1, 8'b10_0_0000_0};

    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", 32'(dut_out()), 32'h0);
    rst_n = 1'b1;

    // reset abandons a burst mid-way
    drive(4'b1001, 5'd4, 1'b1);
    step("rst_grant");
    step("rst_beat1");
    step("rst_beat2");
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(dut_out()), 32'h0);
    model_reset();
    drive(4'b0000, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("rst_idle");
      check("rst_idle_valid", 32'(sel_valid), 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].req, tbl[i].len, tbl[i].rdy);
      step("tbl_model");
      check($sformatf("tbl_%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // stall: ready 1,0,0,1 after grant
    drive(4'b0010, 5'd2, 1'b1);
    step("stall_grant");
    check("stall_grant_sel", 32'(dut_out()), 32'b01_1_0010_0);
    beats = 0;
    step("stall_b1");
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step("stall_hold");
      check("stall_frozen", 32'(dut_out()), 32'b01_1_0010_1);
    end
    drive(4'b0000, 5'd2, 1'b1);
    step("stall_b2");
    check("stall_beats", 32'(beats), 32'd2);
    check("stall_end", 32'(sel_valid), 32'h0);

    // burst_len 0 gives a single beat
    drive(4'b0100, 5'd0, 1'b1);
    step("len0_grant");
    check("len0_last", 32'(last), 32'h1);
    drive(4'b0000, 5'd0, 1'b1);
    step("len0_end");
    check("len0_idle", 32'(sel_valid), 32'h0);

    // max length then back-to-back re-grant of the only requester
    drive(4'b0001, 5'd16, 1'b1);
    step("max_grant");
    beats = 0;
    for (int i = 0; i < 15; i++) step("max_beat");
    check("max_last", 32'(last), 32'h1);
    step("max_final");
    check("max_regrant", 32'({sel_valid, sel, last}), 32'b1_00_0);
    check("max_beats", 32'(beats), 32'd16);
    drive(4'b0000, 5'd0, 1'b0);
    step("max_drop");
    check("max_drop_idle", 32'(sel_valid), 32'h0);

    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // early drop of channel 0 after three beats hands over to channel 3
    drive(4'b1001, 5'd8, 1'b1);
    step("drop_grant");
    check("drop_sel0", 32'(sel), 32'h0);
    for (int i = 0; i < 3; i++) step("drop_beat");
    drive(4'b1000, 5'd2, 1'b0);
    step("drop_end");
    check("drop_sel3", 32'(dut_out()), 32'b11_1_1000_0);
    ready = 1'b1;
    step("drop_b1");
    drive(4'b0000, 5'd2, 1'b1);
    step("drop_b2");
    check("drop_idle", 32'(sel_valid), 32'h0);
    drive(4'b1001, 5'd1, 1'b1);
    step("drop_ptr");
    check("drop_ptr_wrap", 32'(sel), 32'h0);
    drive(4'b0000, 5'd0, 1'b1);
    step("drop_fin");

    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      burst_len = 5'($urandom_range(0, 20));
      ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end
    drive(4'b0000, 5'd0, 1'b0);
    repeat (3) step("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
